// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_pkg (multicycle_controller)                             |
// | Description : Shared types and encodings for the multicycle RV32I control. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } inst_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_IMM   = 2'b01;
    localparam logic [1:0] PC_SRC_ALU   = 2'b10;

    localparam logic [1:0] ALU_A_RS1  = 2'b00;
    localparam logic [1:0] ALU_A_PC   = 2'b01;
    localparam logic [1:0] ALU_A_ZERO = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller_if                                     |
// | Description : Instruction, memory handshake and datapath control bundle.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface multicycle_controller_if;
    logic [31:0] inst;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [3:0]  state_dbg;

    // Controller side
    modport master (
        input  inst, mem_ready, branch_taken,
        output mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, state_dbg
    );

    // Datapath / memory side
    modport slave (
        output inst, mem_ready, branch_taken,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_opcode_decode                                           |
// | Description : Combinational opcode to instruction-class / imm_sel map.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]  opcode_i,
    output inst_class_t cls_o,
    output logic [2:0]  imm_sel_o
);

    always_comb begin
        cls_o     = CLS_ILLEGAL;
        imm_sel_o = IMM_NONE;
        case (opcode_i)
            OP_R:      begin cls_o = CLS_R;      imm_sel_o = IMM_NONE; end
            OP_I:      begin cls_o = CLS_I;      imm_sel_o = IMM_I;    end
            OP_LOAD:   begin cls_o = CLS_LOAD;   imm_sel_o = IMM_I;    end
            OP_STORE:  begin cls_o = CLS_STORE;  imm_sel_o = IMM_S;    end
            OP_BRANCH: begin cls_o = CLS_BRANCH; imm_sel_o = IMM_B;    end
            OP_JAL:    begin cls_o = CLS_JAL;    imm_sel_o = IMM_J;    end
            OP_JALR:   begin cls_o = CLS_JALR;   imm_sel_o = IMM_I;    end
            OP_LUI:    begin cls_o = CLS_LUI;    imm_sel_o = IMM_U;    end
            OP_AUIPC:  begin cls_o = CLS_AUIPC;  imm_sel_o = IMM_U;    end
            default:   begin cls_o = CLS_ILLEGAL; imm_sel_o = IMM_NONE; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller                                        |
// | Description : Multicycle RV32I control FSM (fetch/decode/exec/mem/wb).     |
// |               MULTICYCLE_CTRL_PERF_EN adds cycle_cnt / instret_cnt.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int RESET_TRAP_HALT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             instret_cnt
`endif
);

    state_t      state_q, state_d;
    inst_class_t cls;
    logic [2:0]  dec_imm;
    logic        unused_inst;

    assign unused_inst = ^bus.inst[31:7];

    ctrl_opcode_decode u_decode (
        .opcode_i  (bus.inst[6:0]),
        .cls_o     (cls),
        .imm_sel_o (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_R:                 state_d = S_EXEC_R;
                    CLS_I:                 state_d = S_EXEC_I;
                    CLS_LOAD, CLS_STORE:   state_d = S_MEM_ADDR;
                    CLS_BRANCH:            state_d = S_BRANCH;
                    CLS_JAL:               state_d = S_JAL;
                    CLS_JALR:              state_d = S_JALR;
                    CLS_LUI, CLS_AUIPC:    state_d = S_UPPER;
                    default:               state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_UPPER:    state_d = S_WB_ALU;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_TRAP:     if (RESET_TRAP_HALT == 0) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low regardless of the state being aborted.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = PC_SRC_PLUS4;
        bus.imm_sel   = IMM_NONE;
        bus.alu_src_a = ALU_A_RS1;
        bus.alu_src_b = ALU_B_RS2;
        bus.alu_op    = ALU_OP_ADD;
        bus.reg_write = 1'b0;
        bus.wb_sel    = WB_SEL_ALU;
        bus.illegal   = 1'b0;
        bus.state_dbg = state_q;
        if (rst) begin
            bus.state_dbg = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                S_EXEC_R: begin
                    bus.alu_op = ALU_OP_FUNCT;
                end
                S_EXEC_I: begin
                    bus.imm_sel   = dec_imm;
                    bus.alu_src_b = ALU_B_IMM;
                    bus.alu_op    = ALU_OP_FUNCT;
                end
                S_MEM_ADDR: begin
                    bus.imm_sel   = dec_imm;
                    bus.alu_src_b = ALU_B_IMM;
                end
                S_MEM_RD: begin
                    bus.mem_req = 1'b1;
                end
                S_MEM_WR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                end
                S_WB_ALU: begin
                    bus.reg_write = 1'b1;
                end
                S_WB_MEM: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_SEL_MEM;
                end
                S_BRANCH: begin
                    bus.imm_sel  = dec_imm;
                    bus.alu_op   = ALU_OP_SUB;
                    bus.pc_write = bus.branch_taken;
                    bus.pc_src   = PC_SRC_IMM;
                end
                S_JAL: begin
                    bus.imm_sel   = dec_imm;
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_SEL_PC4;
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = PC_SRC_IMM;
                end
                S_JALR: begin
                    bus.imm_sel   = dec_imm;
                    bus.alu_src_b = ALU_B_IMM;
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_SEL_PC4;
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = PC_SRC_ALU;
                end
                S_UPPER: begin
                    bus.imm_sel   = dec_imm;
                    bus.alu_src_b = ALU_B_IMM;
                    bus.alu_src_a = (cls == CLS_LUI) ? ALU_A_ZERO : ALU_A_PC;
                end
                S_TRAP: begin
                    bus.illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if ((state_q != S_FETCH) && (state_q != S_TRAP) && (state_d == S_FETCH)) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                     |
// | Description : Self-checking bench with a per-instruction behavioural model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_TRAP   = 4'd13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus_if ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller #(.RESET_TRAP_HALT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // Expected per-instruction totals, derived from the instruction class alone.
    task automatic model(input logic [6:0] op, input int wf, input int wm, input logic bt,
                         output int lat, output int regw, output int wbs, output int pcw,
                         output int jsrc, output int mreq, output int mwe, output int imask,
                         output int amask, output int bmask, output int omask);
        bit is_mem = 0;
        lat = 4; regw = 1; wbs = 0; pcw = 1; jsrc = 0; mwe = 0;
        imask = 0; amask = 0; bmask = 0; omask = 0;
        case (op)
            7'b0110011: begin omask = 1 << 2; end
            7'b0010011: begin imask = 1 << 1; bmask = 1 << 1; omask = 1 << 2; end
            7'b0000011: begin lat = 5; wbs = 1; is_mem = 1; imask = 1 << 1; bmask = 1 << 1; end
            7'b0100011: begin regw = 0; is_mem = 1; mwe = wm + 1; imask = 1 << 2; bmask = 1 << 1; end
            7'b1100011: begin lat = 3; regw = 0; pcw = 1 + int'(bt); jsrc = 1; imask = 1 << 3; omask = 1 << 1; end
            7'b1101111: begin lat = 3; wbs = 2; pcw = 2; jsrc = 1; imask = 1 << 5; end
            7'b1100111: begin lat = 3; wbs = 2; pcw = 2; jsrc = 2; imask = 1 << 1; bmask = 1 << 1; end
            7'b0110111: begin imask = 1 << 4; bmask = 1 << 1; amask = 1 << 2; end
            default:    begin imask = 1 << 4; bmask = 1 << 1; amask = 1 << 1; end
        endcase
        lat  = lat + wf + (is_mem ? wm : 0);
        mreq = wf + 1 + (is_mem ? wm + 1 : 0);
    endtask

    // Runs one instruction from a FETCH cycle with a request/ready memory model.
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic bt);
        int e_lat, e_regw, e_wbs, e_pcw, e_jsrc, e_mreq, e_mwe, e_imask, e_amask, e_bmask, e_omask;
        int o_irw = 0, o_ir_at = -1, o_pcw = 0, o_jsrc = 0, o_regw = 0, o_wbs = 0;
        int o_mreq = 0, o_mwe = 0, o_imask = 0, o_amask = 0, o_bmask = 0, o_omask = 0;
        int o_ill = 0, o_fsrc_bad = 0, reqcnt = 0, curwait = wf;
`ifdef MULTICYCLE_CTRL_PERF_EN
        logic [31:0] c0, r0;
`endif
        model(ins[6:0], wf, wm, bt, e_lat, e_regw, e_wbs, e_pcw, e_jsrc, e_mreq, e_mwe,
              e_imask, e_amask, e_bmask, e_omask);
        for (int c = 0; c < e_lat; c++) begin
            @(negedge clk);
            bus_if.inst = ins;
            bus_if.branch_taken = bt;
`ifdef MULTICYCLE_CTRL_PERF_EN
            if (c == 0) begin c0 = cycle_cnt; r0 = instret_cnt; end
`endif
            if (bus_if.mem_req) begin
                if (reqcnt >= curwait) begin
                    bus_if.mem_ready = 1'b1; reqcnt = 0; curwait = wm;
                end else begin
                    bus_if.mem_ready = 1'b0; reqcnt++;
                end
            end else begin
                bus_if.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus_if.ir_write) begin o_irw++; o_ir_at = c; end
            if (bus_if.pc_write) begin
                o_pcw++;
                if (bus_if.ir_write) o_fsrc_bad += (bus_if.pc_src != 2'b00) ? 1 : 0;
                else o_jsrc = int'(bus_if.pc_src);
            end
            if (bus_if.reg_write) begin o_regw++; o_wbs = int'(bus_if.wb_sel); end
            o_mreq += int'(bus_if.mem_req);
            o_mwe  += int'(bus_if.mem_we);
            o_ill  += int'(bus_if.illegal);
            if (bus_if.imm_sel   != 3'd0) o_imask |= 1 << bus_if.imm_sel;
            if (bus_if.alu_src_a != 2'd0) o_amask |= 1 << bus_if.alu_src_a;
            if (bus_if.alu_src_b != 2'd0) o_bmask |= 1 << bus_if.alu_src_b;
            if (bus_if.alu_op    != 2'd0) o_omask |= 1 << bus_if.alu_op;
        end
        @(posedge clk);
        #1;
        n_checks += 12;
        if (bus_if.state_dbg !== ST_FETCH) begin n_errors++; $display("FAIL end_state inst=%h got=%0d exp=%0d", ins, bus_if.state_dbg, ST_FETCH); end
        if (o_irw != 1 || o_ir_at != wf) begin n_errors++; $display("FAIL ir_write inst=%h count=%0d at=%0d exp count=1 at=%0d", ins, o_irw, o_ir_at, wf); end
        if (o_pcw != e_pcw) begin n_errors++; $display("FAIL pc_write_count inst=%h got=%0d exp=%0d", ins, o_pcw, e_pcw); end
        if (e_pcw > 1 && o_jsrc != e_jsrc) begin n_errors++; $display("FAIL pc_src inst=%h got=%0d exp=%0d", ins, o_jsrc, e_jsrc); end
        if (o_regw != e_regw || (e_regw != 0 && o_wbs != e_wbs)) begin n_errors++; $display("FAIL reg_write inst=%h count=%0d wb_sel=%0d exp count=%0d wb_sel=%0d", ins, o_regw, o_wbs, e_regw, e_wbs); end
        if (o_mreq != e_mreq) begin n_errors++; $display("FAIL mem_req_cycles inst=%h got=%0d exp=%0d", ins, o_mreq, e_mreq); end
        if (o_mwe != e_mwe) begin n_errors++; $display("FAIL mem_we_cycles inst=%h got=%0d exp=%0d", ins, o_mwe, e_mwe); end
        if (o_imask != e_imask) begin n_errors++; $display("FAIL imm_sel_set inst=%h got=%b exp=%b", ins, o_imask, e_imask); end
        if (o_amask != e_amask) begin n_errors++; $display("FAIL alu_src_a_set inst=%h got=%b exp=%b", ins, o_amask, e_amask); end
        if (o_bmask != e_bmask) begin n_errors++; $display("FAIL alu_src_b_set inst=%h got=%b exp=%b", ins, o_bmask, e_bmask); end
        if (o_omask != e_omask) begin n_errors++; $display("FAIL alu_op_set inst=%h got=%b exp=%b", ins, o_omask, e_omask); end
        if (o_ill != 0 || o_fsrc_bad != 0) begin n_errors++; $display("FAIL illegal_or_fetch_src inst=%h illegal=%0d badsrc=%0d exp 0 0", ins, o_ill, o_fsrc_bad); end
`ifdef MULTICYCLE_CTRL_PERF_EN
        n_checks++;
        if (cycle_cnt - c0 != 32'(e_lat) || instret_cnt - r0 != 32'd1) begin
            n_errors++; $display("FAIL perf_counters inst=%h dcycle=%0d dinstret=%0d exp %0d 1", ins, cycle_cnt - c0, instret_cnt - r0, e_lat);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_if.mem_ready = 1'b0; bus_if.inst = 32'd0; bus_if.branch_taken = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if ({bus_if.mem_req, bus_if.mem_we, bus_if.ir_write, bus_if.pc_write, bus_if.pc_src,
                 bus_if.imm_sel, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write,
                 bus_if.wb_sel, bus_if.illegal, bus_if.state_dbg} !== 24'd0) begin
                n_errors++; $display("FAIL reset_outputs got mem_req=%b state=%0d illegal=%b exp all zero", bus_if.mem_req, bus_if.state_dbg, bus_if.illegal);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (bus_if.state_dbg !== ST_FETCH || bus_if.mem_req !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_fetch state=%0d mem_req=%b exp state=0 mem_req=1", bus_if.state_dbg, bus_if.mem_req);
        end
    endtask

    task automatic test_addi();
        @(negedge clk); bus_if.inst = 32'h00500093; bus_if.mem_ready = 1'b1; #1;
        n_checks++;
        if ({bus_if.mem_req, bus_if.ir_write, bus_if.pc_write, bus_if.pc_src} !== 5'b11100) begin
            n_errors++; $display("FAIL addi_fetch req/ir/pc/src=%b exp=11100", {bus_if.mem_req, bus_if.ir_write, bus_if.pc_write, bus_if.pc_src});
        end
        @(negedge clk); bus_if.mem_ready = 1'b0; #1;
        n_checks++;
        if (bus_if.state_dbg !== ST_DECODE || bus_if.imm_sel !== 3'd0 || bus_if.reg_write !== 1'b0) begin
            n_errors++; $display("FAIL addi_decode state=%0d imm_sel=%0d exp state=1 imm_sel=0", bus_if.state_dbg, bus_if.imm_sel);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus_if.imm_sel, bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write} !== 8'b001_01_10_0) begin
            n_errors++; $display("FAIL addi_exec imm/srcb/op/rw=%b exp=00101100", {bus_if.imm_sel, bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write});
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus_if.reg_write !== 1'b1 || bus_if.wb_sel !== 2'b00) begin
            n_errors++; $display("FAIL addi_wb reg_write=%b wb_sel=%0d exp 1 0", bus_if.reg_write, bus_if.wb_sel);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.state_dbg !== ST_FETCH) begin n_errors++; $display("FAIL addi_end state=%0d exp=0", bus_if.state_dbg); end
    endtask

    task automatic test_store_wait();
        run_instr(32'h00112223, 0, 3, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(32'h00000463, 0, 0, 1'b1);
        run_instr(32'h00000463, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            r = $urandom();
            run_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_trap();
        @(negedge clk); bus_if.inst = 32'hFFFFFFFF; bus_if.mem_ready = 1'b1; #1;
        @(negedge clk); bus_if.mem_ready = 1'b0; #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); bus_if.mem_ready = 1'($urandom_range(0, 1)); #1;
            n_checks++;
            if (bus_if.illegal !== 1'b1 || bus_if.mem_req !== 1'b0 || bus_if.state_dbg !== ST_TRAP) begin
                n_errors++; $display("FAIL trap_hold cycle=%0d illegal=%b mem_req=%b state=%0d exp 1 0 13", k, bus_if.illegal, bus_if.mem_req, bus_if.state_dbg);
            end
        end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++;
        if (bus_if.illegal !== 1'b0 || bus_if.mem_req !== 1'b0) begin
            n_errors++; $display("FAIL trap_reset illegal=%b mem_req=%b exp 0 0", bus_if.illegal, bus_if.mem_req);
        end
        @(negedge clk); rst = 1'b0; bus_if.mem_ready = 1'b0; #1;
        n_checks++;
        if (bus_if.state_dbg !== ST_FETCH || bus_if.mem_req !== 1'b1 || bus_if.illegal !== 1'b0) begin
            n_errors++; $display("FAIL trap_restart state=%0d mem_req=%b illegal=%b exp 0 1 0", bus_if.state_dbg, bus_if.mem_req, bus_if.illegal);
        end
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk); bus_if.inst = 32'h0000A103; bus_if.mem_ready = 1'b1; #1;
        @(negedge clk); bus_if.mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b0) begin
                n_errors++; $display("FAIL load_wait cycle=%0d mem_req=%b mem_we=%b exp 1 0", k, bus_if.mem_req, bus_if.mem_we);
            end
        end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++;
        if (bus_if.mem_req !== 1'b0 || bus_if.reg_write !== 1'b0 || bus_if.state_dbg !== ST_FETCH) begin
            n_errors++; $display("FAIL reset_abort mem_req=%b reg_write=%b state=%0d exp 0 0 0", bus_if.mem_req, bus_if.reg_write, bus_if.state_dbg);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (bus_if.state_dbg !== ST_FETCH || bus_if.mem_req !== 1'b1 || bus_if.reg_write !== 1'b0) begin
            n_errors++; $display("FAIL reset_abort_after state=%0d mem_req=%b reg_write=%b exp 0 1 0", bus_if.state_dbg, bus_if.mem_req, bus_if.reg_write);
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        n_checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            n_errors++; $display("FAIL perf_reset cycle_cnt=%0d instret_cnt=%0d exp 0 0", cycle_cnt, instret_cnt);
        end
`endif
        run_instr(32'h0000A103, 1, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_wait();
        test_branch();
        test_back_to_back();
        test_reset_mid_mem();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
